// File: rtl/calendar_if.sv
// Display-path bus of the calendar counter: run/load control in, BCD digits
// and one-cycle event pulses out.
interface calendar_if;
  logic        run;
  logic        load;
  logic [55:0] set_bcd;

  logic [3:0]  yil_binlik;
  logic [3:0]  yil_yuzluk;
  logic [3:0]  yil_onluk;
  logic [3:0]  yil_birlik;
  logic        ay_onluk;
  logic [3:0]  ay_birlik;
  logic [2:0]  gun_onluk;
  logic [3:0]  gun_birlik;
  logic [2:0]  saat_onluk;
  logic [3:0]  saat_birlik;
  logic [2:0]  dakika_onluk;
  logic [3:0]  dakika_birlik;
  logic [2:0]  saniye_onluk;
  logic [3:0]  saniye_birlik;
  logic        sec_tick;
  logic        load_err;

  modport master (
    output run, load, set_bcd,
    input  yil_binlik, yil_yuzluk, yil_onluk, yil_birlik,
    input  ay_onluk, ay_birlik, gun_onluk, gun_birlik,
    input  saat_onluk, saat_birlik, dakika_onluk, dakika_birlik,
    input  saniye_onluk, saniye_birlik, sec_tick, load_err
  );

  modport slave (
    input  run, load, set_bcd,
    output yil_binlik, yil_yuzluk, yil_onluk, yil_birlik,
    output ay_onluk, ay_birlik, gun_onluk, gun_birlik,
    output saat_onluk, saat_birlik, dakika_onluk, dakika_birlik,
    output saniye_onluk, saniye_birlik, sec_tick, load_err
  );
endinterface

// File: rtl/calendar_counter.sv
// BCD real-time calendar: divides the pixel clock to a one-second tick and
// advances YYYY-MM-DD hh:mm:ss with Gregorian leap years and validated loads.
module calendar_counter #(
  parameter int unsigned TICK_DIV  = 148500000,
  parameter logic [55:0] RESET_BCD = 56'h20240101000000
) (
  input  logic       clk_148_5MHz,
  input  logic       reset,
  calendar_if.slave  bus
);

  typedef struct packed {
    logic [3:0] y3;
    logic [3:0] y2;
    logic [3:0] y1;
    logic [3:0] y0;
    logic       mo_t;
    logic [3:0] mo_o;
    logic [2:0] dy_t;
    logic [3:0] dy_o;
    logic [2:0] hr_t;
    logic [3:0] hr_o;
    logic [2:0] mi_t;
    logic [3:0] mi_o;
    logic [2:0] se_t;
    logic [3:0] se_o;
  } cal_t;

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  // Tens digits keep only the low bits of their nibble.
  localparam cal_t RESET_CAL = {RESET_BCD[55:40], RESET_BCD[36:32], RESET_BCD[30:24],
                                RESET_BCD[22:16], RESET_BCD[14:8], RESET_BCD[6:0]};

  function automatic logic div4(input logic [3:0] tens, input logic [3:0] ones);
    if (tens[0]) return (ones == 4'd2) || (ones == 4'd6);
    return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
  endfunction

  function automatic logic is_leap(input logic [15:0] year);
    if (year[7:0] != 8'h00) return div4(year[7:4], year[3:0]);
    return div4(year[15:12], year[11:8]);
  endfunction

  function automatic logic [7:0] last_day(input logic [7:0] month, input logic leap);
    case (month)
      8'h02:                      last_day = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: last_day = 8'h30;
      default:                    last_day = 8'h31;
    endcase
  endfunction

  function automatic logic [3:0] inc_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  cal_t          cal_q;
  cal_t          cal_nxt;
  cal_t          cal_set;
  logic [PW-1:0] presc;
  logic          tick;
  logic          sec_tick_q;
  logic          load_err_q;
  logic          set_valid;
  logic          nib_ok;
  logic [7:0]    cur_last;
  logic          se_wrap, mi_wrap, hr_wrap, dy_wrap, mo_wrap;
  logic          c_min, c_hr, c_day, c_mo, c_yr;

  assign tick = bus.run && (presc == TERM);

  // ---------------------------------------------------------------- load check
  assign cal_set = {bus.set_bcd[55:40], bus.set_bcd[36:32], bus.set_bcd[30:24],
                    bus.set_bcd[22:16], bus.set_bcd[14:8], bus.set_bcd[6:0]};

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    nib_ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (bus.set_bcd[4*i +: 4] > 4'd9) nib_ok = 1'b0;
    end
  end

  // BCD compares order correctly once every nibble is known to be a digit.
  assign set_valid = nib_ok
                  && (bus.set_bcd[39:32] >= 8'h01) && (bus.set_bcd[39:32] <= 8'h12)
                  && (bus.set_bcd[31:24] >= 8'h01)
                  && (bus.set_bcd[31:24] <= last_day(bus.set_bcd[39:32],
                                                     is_leap(bus.set_bcd[55:40])))
                  && (bus.set_bcd[23:16] <= 8'h23)
                  && (bus.set_bcd[15:8]  <= 8'h59)
                  && (bus.set_bcd[7:0]   <= 8'h59);

  // ------------------------------------------------------------- carry chain
  assign cur_last = last_day({3'b000, cal_q.mo_t, cal_q.mo_o},
                             is_leap({cal_q.y3, cal_q.y2, cal_q.y1, cal_q.y0}));

  assign se_wrap = ({cal_q.se_t, cal_q.se_o} == 7'h59);
  assign mi_wrap = ({cal_q.mi_t, cal_q.mi_o} == 7'h59);
  assign hr_wrap = ({cal_q.hr_t, cal_q.hr_o} == 7'h23);
  assign dy_wrap = ({1'b0, cal_q.dy_t, cal_q.dy_o} == cur_last);
  assign mo_wrap = cal_q.mo_t && (cal_q.mo_o == 4'd2);

  assign c_min = se_wrap;
  assign c_hr  = c_min && mi_wrap;
  assign c_day = c_hr && hr_wrap;
  assign c_mo  = c_day && dy_wrap;
  assign c_yr  = c_mo && mo_wrap;

  always_comb begin
    cal_nxt = cal_q;
    cal_nxt.se_o = inc_digit(cal_q.se_o);
    cal_nxt.se_t = se_wrap ? 3'd0 : cal_q.se_t + {2'b00, cal_q.se_o == 4'd9};
    if (c_min) begin
      cal_nxt.mi_o = inc_digit(cal_q.mi_o);
      cal_nxt.mi_t = mi_wrap ? 3'd0 : cal_q.mi_t + {2'b00, cal_q.mi_o == 4'd9};
    end
    if (c_hr) begin
      cal_nxt.hr_o = hr_wrap ? 4'd0 : inc_digit(cal_q.hr_o);
      cal_nxt.hr_t = hr_wrap ? 3'd0 : cal_q.hr_t + {2'b00, cal_q.hr_o == 4'd9};
    end
    if (c_day) begin
      cal_nxt.dy_o = dy_wrap ? 4'd1 : inc_digit(cal_q.dy_o);
      cal_nxt.dy_t = dy_wrap ? 3'd0 : cal_q.dy_t + {2'b00, cal_q.dy_o == 4'd9};
    end
    if (c_mo) begin
      cal_nxt.mo_o = mo_wrap ? 4'd1 : inc_digit(cal_q.mo_o);
      cal_nxt.mo_t = mo_wrap ? 1'b0 : (cal_q.mo_t || (cal_q.mo_o == 4'd9));
    end
    // Year digits ripple through 9999 -> 0000 naturally.
    if (c_yr) begin
      cal_nxt.y0 = inc_digit(cal_q.y0);
      if (cal_q.y0 == 4'd9) begin
        cal_nxt.y1 = inc_digit(cal_q.y1);
        if (cal_q.y1 == 4'd9) begin
          cal_nxt.y2 = inc_digit(cal_q.y2);
          if (cal_q.y2 == 4'd9) cal_nxt.y3 = inc_digit(cal_q.y3);
        end
      end
    end
  end

  // ---------------------------------------------------------------- registers
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_148_5MHz or negedge reset) begin
    if (!reset) begin
      cal_q      <= RESET_CAL;
      presc      <= '0;
      sec_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      sec_tick_q <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.load) begin
        // A load swallows a coincident tick; a rejected one also freezes the prescaler.
        if (set_valid) begin
          cal_q <= cal_set;
          presc <= '0;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (tick) begin
        cal_q      <= cal_nxt;
        presc      <= '0;
        sec_tick_q <= 1'b1;
      end else if (bus.run) begin
        presc <= presc + PW'(1);
      end
    end
  end

  assign bus.yil_binlik    = cal_q.y3;
  assign bus.yil_yuzluk    = cal_q.y2;
  assign bus.yil_onluk     = cal_q.y1;
  assign bus.yil_birlik    = cal_q.y0;
  assign bus.ay_onluk      = cal_q.mo_t;
  assign bus.ay_birlik     = cal_q.mo_o;
  assign bus.gun_onluk     = cal_q.dy_t;
  assign bus.gun_birlik    = cal_q.dy_o;
  assign bus.saat_onluk    = cal_q.hr_t;
  assign bus.saat_birlik   = cal_q.hr_o;
  assign bus.dakika_onluk  = cal_q.mi_t;
  assign bus.dakika_birlik = cal_q.mi_o;
  assign bus.saniye_onluk  = cal_q.se_t;
  assign bus.saniye_birlik = cal_q.se_o;
  assign bus.sec_tick      = sec_tick_q;
  assign bus.load_err      = load_err_q;

endmodule
